// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-to-parallel frame receiver.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Bit-count register width; never below one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  // Even-parity check over a zero-extended vector: 1 means odd number of ones.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry valid/ready holding register for received words and their parity sideband.
module sipo_out_slot
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             perr,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             parity_err,
  output logic             full
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             parity_err_q, parity_err_d;

  // Slot cannot take a new word this edge: occupied and not being drained.
  assign full = dout_valid_q & ~dout_ready;

  // Load a new word when there is room; otherwise drain on a handshake.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    parity_err_d = parity_err_q;
    if (load && !full) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
      parity_err_d = perr;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign parity_err = parity_err_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// MSB-first strobed serial receiver with start-of-frame resync, output slot and
// sticky overrun. Optional even-parity bit per frame: define SIPO_FRAME_RX_PARITY_EN.
module sipo_frame_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  input  logic             sdi_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
`ifdef SIPO_FRAME_RX_PARITY_EN
  // Full word is held across the parity bit.
  localparam int SH_W = WIDTH;
`else
  // The last data bit comes straight from sdi, so only WIDTH-1 bits are stored.
  localparam int SH_W = WIDTH - 1;
`endif

  state_e           state_q, state_d;
  logic [SH_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_c;
  logic             complete_c;
  logic             perr_c;
  logic             slot_full;

  assign shifted = {shreg_q[WIDTH-2:0], sdi};

  // Next-state logic: framing, shifting and word completion.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    complete_c = 1'b0;
    word_c     = shifted;
    perr_c     = 1'b0;
    if (sdi_vld) begin
      if (sof) begin
        // Start marker always begins a new frame, discarding any partial one.
        shreg_d = SH_W'(sdi);
        cnt_d   = CNT_W'(1);
        state_d = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_d = SH_W'(shifted);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              cnt_d = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
              state_d = PARITY;
`else
              complete_c = 1'b1;
              state_d    = IDLE;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
`ifdef SIPO_FRAME_RX_PARITY_EN
          PARITY: begin
            complete_c = 1'b1;
            word_c     = shreg_q;
            perr_c     = even_parity(64'({shreg_q, sdi}));
            state_d    = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // A completed word that finds the slot full is dropped; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (complete_c && slot_full) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  // Control and shift registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  sipo_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (complete_c),
    .word       (word_c),
    .perr       (perr_c),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err),
    .full       (slot_full)
  );

  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: directed scenarios plus random strobes, checked against
// a bit-list reference model of framing, output slot and overrun.
module tb_sipo_frame_rx;

  localparam int W = 4;
`ifdef SIPO_FRAME_RX_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         sdi = 1'b0, sdi_vld = 1'b0, sof = 1'b0;
  logic         dout_ready = 1'b0, clr_ovr = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid, parity_err, overrun, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int           m_bits[$];
  logic         m_active;
  logic [W-1:0] m_dout;
  logic         m_valid, m_perr, m_ovr;

  always #5 clk = ~clk;

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sdi        (sdi),
    .sdi_vld    (sdi_vld),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_active = 1'b0;
    m_dout   = '0;
    m_valid  = 1'b0;
    m_perr   = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // One clock edge of the reference: collect bits of the current frame as a list,
  // build the word arithmetically once NB bits are in, then apply the slot rules.
  task automatic model_edge();
    bit done = 1'b0;
    bit accept;
    int word = 0;
    int ones = 0;
    if (sdi_vld) begin
      if (sof) begin
        m_bits.delete();
        m_bits.push_back(int'(sdi));
        m_active = 1'b1;
      end else if (m_active) begin
        m_bits.push_back(int'(sdi));
      end
      if (m_active && m_bits.size() == NB) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) word = word * 2 + m_bits[i];
        foreach (m_bits[i]) ones += m_bits[i];
        m_bits.delete();
        m_active = 1'b0;
      end
    end
    accept = !m_valid || dout_ready;
    if (done && accept) begin
      m_dout  = W'(word);
      m_valid = 1'b1;
      m_perr  = PAR && (ones % 2 == 1);
    end else if (done) begin
      m_ovr = 1'b1;
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
    if (!(done && !accept) && clr_ovr) m_ovr = 1'b0;
  endtask

  task automatic chk_model();
    chk("dout",       32'(dout),       32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("busy",       32'(busy),       32'(m_active));
  endtask

  task automatic cyc(input logic v, input logic s, input logic d,
                     input logic r, input logic c);
    sdi_vld    = v;
    sof        = s;
    sdi        = d;
    dout_ready = r;
    clr_ovr    = c;
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  // Send one frame MSB first; par < 0 appends the correct even-parity bit (parity build).
  task automatic send(input logic [W-1:0] word, input int gap, input logic rdy,
                      input logic rdy_last, input int par);
    for (int i = 0; i < NB; i++) begin
      logic b;
      if (i < W) b = word[W-1-i];
      else       b = (par < 0) ? ^word : par[0];
      cyc(1'b1, i == 0, b, (i == NB - 1) ? rdy_last : rdy, 1'b0);
      if (i != NB - 1) repeat (gap) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_dout",       32'(dout),       32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_overrun",    32'(overrun),    32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic v, s, d, r, c;
    #1;
    do_reset();

    // Basic frame, always ready
    send(4'hB, 0, 1'b1, 1'b1, -1);
    chk("basic_dout",  32'(dout),       32'hB);
    chk("basic_valid", 32'(dout_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_valid_1cyc", 32'(dout_valid), 32'h0);

    // Stray strobe in IDLE, then gapped frame
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("stray_busy", 32'(busy), 32'h0);
    send(4'h6, 3, 1'b1, 1'b1, -1);
    chk("gap_dout",  32'(dout),       32'h6);
    chk("gap_valid", 32'(dout_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure and overrun
    send(4'hA, 0, 1'b0, 1'b0, -1);
    chk("bp_first", 32'(dout), 32'hA);
    send(4'h5, 0, 1'b0, 1'b0, -1);
    chk("bp_hold",    32'(dout),    32'hA);
    chk("bp_overrun", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_clr", 32'(overrun), 32'h0);
    send(4'h5, 0, 1'b0, 1'b1, -1);
    chk("bp_swap_dout",    32'(dout),       32'h5);
    chk("bp_swap_valid",   32'(dout_valid), 32'h1);
    chk("bp_swap_overrun", 32'(overrun),    32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Resync on a new start marker mid-frame
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send(4'h3, 0, 1'b1, 1'b1, -1);
    chk("resync_dout",    32'(dout),    32'h3);
    chk("resync_overrun", 32'(overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame, then a clean frame
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midframe_busy", 32'(busy), 32'h1);
    do_reset();
    send(4'h9, 0, 1'b1, 1'b1, -1);
    chk("post_rst_dout", 32'(dout), 32'h9);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_FRAME_RX_PARITY_EN
    // Parity good, then parity bad
    send(4'hB, 0, 1'b1, 1'b1, 1);
    chk("par_ok_dout", 32'(dout),       32'hB);
    chk("par_ok_err",  32'(parity_err), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'hB, 0, 1'b1, 1'b1, 0);
    chk("par_bad_err",   32'(parity_err), 32'h1);
    chk("par_bad_valid", 32'(dout_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Random strobes, markers, back-pressure and clears
    repeat (800) begin
      v = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 9) < 2);
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      cyc(v, s, d, r, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
